// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch-stage PC generation, synchronous instruction-memory
// read issue, and a 2-entry {pc, instr} queue feeding the IF/ID register.
// Redirects flush all wrong-path work; idle output shows NOP_INSTR.
module instr_fetch_unit #(
    parameter int unsigned           PC_W      = 8,
    parameter int unsigned           INSTR_W   = 32,
    parameter logic [PC_W-1:0]       RESET_PC  = 8'h00,
    parameter logic [INSTR_W-1:0]    NOP_INSTR = 32'hF800_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     out_pc,
    output logic [INSTR_W-1:0]  out_instr
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DROP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [PC_W-1:0]      r_pc;
    logic                 r_inflight;
    logic [PC_W-1:0]      r_inflight_pc;

    logic [PC_W-1:0]      r_q_pc    [2];
    logic [INSTR_W-1:0]   r_q_instr [2];
    logic                 r_rd_ptr;
    logic                 r_wr_ptr;
    logic [1:0]           r_count;

    logic                 w_pop;
    logic                 w_push;
    logic [2:0]           w_credit;

    // Next-state decode plus all combinational outputs and handshake terms.
    always_comb begin
        w_state_nxt = ST_RUN;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        w_credit    = '0;
        imem_req    = 1'b0;
        imem_addr   = r_pc;
        out_valid   = 1'b0;
        out_pc      = '0;
        out_instr   = NOP_INSTR;

        // A redirect with a read outstanding must discard the next response.
        if (redirect_valid && r_inflight) begin
            w_state_nxt = ST_DROP;
        end

        out_valid = (r_count != 2'd0) && !redirect_valid;
        w_pop     = out_valid && out_ready;
        if (out_valid) begin
            out_pc    = r_q_pc[r_rd_ptr];
            out_instr = r_q_instr[r_rd_ptr];
        end

        // Occupancy after this edge if nothing new were requested; never
        // underflows because a pop requires at least one queued entry.
        w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        imem_req = (r_state != ST_BOOT) && !redirect_valid && (w_credit < 3'd2);

        w_push = r_inflight && (r_state != ST_DROP) && !redirect_valid;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC and outstanding-read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_pc          <= r_pc + 1'b1;
                r_inflight_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end
        end
    end

    // Queue pointers and occupancy; flushed by reset or redirect.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents are only meaningful while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_inflight_pc;
            r_q_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: the expected instruction stream is a run of
// consecutive PCs from the last reset/redirect target paired with memory
// contents; a monitor pops and compares on every accepted output.
module tb_instr_fetch_unit;

    localparam logic [7:0]  RESET_PC = 8'h00;
    localparam logic [31:0] NOP      = 32'hF800_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_pc;
    logic [31:0] out_instr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [256];

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    instr_fetch_unit #(
        .PC_W(8),
        .INSTR_W(32),
        .RESET_PC(RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fetch order is simply consecutive addresses (mod 256) from the target.
    task automatic expect_stream(input logic [7:0] start);
        sb.delete();
        for (int i = 0; i < 512; i++) begin
            logic [7:0] a;
            a = start + 8'(i);
            sb.push_back('{pc: a, instr: mem[a]});
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pops plus idle/hold/redirect output rules.
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic        p_flush = 1'b1;
    logic [7:0]  p_pc = '0;
    logic [31:0] p_instr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid) begin
                check("idle_pc", 64'(out_pc), 64'(0));
                check("idle_instr", 64'(out_instr), 64'(NOP));
            end
            if (redirect_valid) begin
                check("redir_out_valid", 64'(out_valid), 64'(0));
                check("redir_imem_req", 64'(imem_req), 64'(0));
            end
            if (!p_flush && p_valid && !p_ready && !redirect_valid) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_pc", 64'(out_pc), 64'(p_pc));
                check("hold_instr", 64'(out_instr), 64'(p_instr));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got output pc %0h expected none", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", 64'(out_pc), 64'(e.pc));
                    check("sb_instr", 64'(out_instr), 64'(e.instr));
                end
            end
        end
        p_valid = out_valid;
        p_ready = out_ready;
        p_pc    = out_pc;
        p_instr = out_instr;
        p_flush = rst | redirect_valid;
    end

    // Ends in C0 (first cycle with rst=0) after checking reset values.
    task automatic do_reset();
        next();
        rst = 1'b1;
        redirect_valid = 1'b0;
        next();
        rst = 1'b0;
        out_ready = 1'b1;
        expect_stream(RESET_PC);
        @(negedge clk);
        check("rst_imem_req", 64'(imem_req), 64'(0));
        check("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_pc", 64'(out_pc), 64'(0));
        check("rst_out_instr", 64'(out_instr), 64'(NOP));
    endtask

    task automatic boot_seq(input bit stall);
        next();
        @(negedge clk);
        check("c1_req", 64'(imem_req), 64'(1));
        check("c1_addr", 64'(imem_addr), 64'(RESET_PC));
        check("c1_valid", 64'(out_valid), 64'(0));
        next();
        @(negedge clk);
        check("c2_req", 64'(imem_req), 64'(1));
        check("c2_addr", 64'(imem_addr), 64'(RESET_PC + 8'd1));
        check("c2_valid", 64'(out_valid), 64'(0));
        next();
        if (stall) out_ready = 1'b0;
        @(negedge clk);
        check("c3_valid", 64'(out_valid), 64'(1));
        check("c3_pc", 64'(out_pc), 64'(RESET_PC));
    endtask

    task automatic stream_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next();
            @(negedge clk);
            check("stream_valid", 64'(out_valid), 64'(1));
        end
    endtask

    task automatic redirect_to(input logic [7:0] tgt);
        next();
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        out_ready = 1'b1;
        expect_stream(tgt);
        @(negedge clk);
        check("r0_valid", 64'(out_valid), 64'(0));
        check("r0_req", 64'(imem_req), 64'(0));
        next();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("r1_req", 64'(imem_req), 64'(1));
        check("r1_addr", 64'(imem_addr), 64'(tgt));
        check("r1_valid", 64'(out_valid), 64'(0));
        next();
        @(negedge clk);
        check("r2_valid", 64'(out_valid), 64'(0));
        next();
        @(negedge clk);
        check("r3_valid", 64'(out_valid), 64'(1));
        check("r3_pc", 64'(out_pc), 64'(tgt));
    endtask

    task automatic stall_cycles(input int n);
        next();
        out_ready = 1'b0;
        for (int i = 1; i < n; i++) next();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);

        // Free run from reset.
        do_reset();
        boot_seq(1'b0);
        stream_cycles(20);

        // Back-pressure from C3, then release.
        do_reset();
        boot_seq(1'b1);
        check("c3_stall_req", 64'(imem_req), 64'(0));
        for (int i = 0; i < 4; i++) begin
            next();
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_pc", 64'(out_pc), 64'(RESET_PC));
            check("stall_req", 64'(imem_req), 64'(0));
        end
        next();
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 64'(out_valid), 64'(1));
        stream_cycles(6);

        // Redirect while streaming with a read outstanding and a valid head.
        redirect_to(8'h40);
        stream_cycles(3);

        // PC wrap.
        redirect_to(8'hFE);
        stream_cycles(5);

        // Redirect with a full queue and nothing outstanding.
        stall_cycles(3);
        redirect_to(8'h80);
        stream_cycles(3);

        // Reset mid-stream with a full queue.
        stall_cycles(3);
        do_reset();
        boot_seq(1'b0);
        stream_cycles(4);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            int r;
            next();
            rst = 1'b0;
            redirect_valid = 1'b0;
            out_ready = ($urandom_range(3) != 0);
            r = $urandom_range(99);
            if (r == 0) begin
                rst = 1'b1;
                for (int i = 0; i < 256; i++) mem[i] = $urandom;
                expect_stream(RESET_PC);
            end else if (r < 6) begin
                redirect_valid = 1'b1;
                redirect_pc = 8'($urandom);
                expect_stream(redirect_pc);
            end
        end
        next();
        rst = 1'b0;
        redirect_valid = 1'b0;
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got no completion expected finish within 1ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
